// File: rtl/hazard_sb.sv
// rtl/hazard_sb.sv - pipeline hazard/forwarding controller with in-flight destination scoreboard
module hazard_sb #(
    parameter int DEPTH  = 3,
    parameter int REG_W  = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   ext_stall,
    input  logic                                   flush,
    input  logic                                   id_valid,
    input  logic [REG_W-1:0]                       id_rs1,
    input  logic                                   id_rs1_en,
    input  logic [REG_W-1:0]                       id_rs2,
    input  logic                                   id_rs2_en,
    input  logic [REG_W-1:0]                       id_rd,
    input  logic                                   id_rd_en,
    input  logic [1:0]                             id_class,
    input  logic                                   id_early,
    input  logic                                   mc_done,
    output logic                                   stall_fe,
    output logic [DEPTH-1:0]                       stall_be,
    output logic                                   issue,
    output logic                                   fw_a,
    output logic [((DEPTH>1)?$clog2(DEPTH):1)-1:0] fw_sel_a,
    output logic                                   fw_b,
    output logic [((DEPTH>1)?$clog2(DEPTH):1)-1:0] fw_sel_b,
    output logic [CNT_W-1:0]                       stall_cnt
);
    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] CLS_LOAD = 2'd1;
    localparam logic [1:0] CLS_SYS  = 2'd2;
    localparam logic [1:0] CLS_MC   = 2'd3;

    // Scoreboard: per-slot valid, destination and earliest bypassable slot.
    // The multi-cycle flag only matters while the op sits in slot 0.
    logic [DEPTH-1:0] v_q, v_d;
    logic [REG_W-1:0] rd_q [DEPTH];
    logic [REG_W-1:0] rd_d [DEPTH];
    logic [SEL_W-1:0] av_q [DEPTH];
    logic [SEL_W-1:0] av_d [DEPTH];
    logic             mc0_q, mc0_d;
    logic             fw_a_q, fw_a_d, fw_b_q, fw_b_d;
    logic [SEL_W-1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             mc_wait, hazard;
    logic [1:0]       src_haz, src_byp;
    logic [SEL_W-1:0] src_sel [2];
    logic [REG_W-1:0] src;
    logic             src_en, found;
    logic [SEL_W-1:0] match_av;
    int               match;

    assign mc_wait = v_q[0] && mc0_q && !mc_done;

    // Youngest matching producer wins; older copies of the same rd are stale.
    always_comb begin
        src_haz    = '0;
        src_byp    = '0;
        src_sel[0] = '0;
        src_sel[1] = '0;
        src        = '0;
        src_en     = 1'b0;
        found      = 1'b0;
        match_av   = '0;
        match      = 0;
        for (int s = 0; s < 2; s++) begin
            src    = (s == 0) ? id_rs1 : id_rs2;
            src_en = ((s == 0) ? id_rs1_en : id_rs2_en) && (src != '0);
            found  = 1'b0;
            match  = 0;
            match_av = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (v_q[i] && (rd_q[i] == src)) begin
                    found    = 1'b1;
                    match    = i;
                    match_av = av_q[i];
                end
            end
            if (src_en && found) begin
                if ((FWD_EN != 0) &&
                    (id_early ? ((match == DEPTH - 1) && (int'(match_av) <= match))
                              : (match >= int'(match_av)))) begin
                    src_byp[s] = 1'b1;
                    src_sel[s] = SEL_W'(match);
                end else begin
                    src_haz[s] = 1'b1;
                end
            end
        end
    end

    assign hazard   = |src_haz;
    assign stall_fe = rst | ext_stall | mc_wait | (id_valid & hazard & ~flush);
    assign issue    = id_valid & ~stall_fe & ~flush;
    assign stall_be = {DEPTH{rst | ext_stall}} | {{(DEPTH-1){1'b0}}, mc_wait};

    always_comb begin
        v_d     = v_q;
        rd_d    = rd_q;
        av_d    = av_q;
        mc0_d   = mc0_q;
        fw_a_d  = fw_a_q;
        fw_b_d  = fw_b_q;
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        cnt_d   = cnt_q;
        if (!ext_stall) begin
            // A held slot 0 leaves a bubble behind it in slot 1.
            for (int i = DEPTH - 1; i >= 1; i--) begin
                v_d[i]  = v_q[i-1] && !((i == 1) && mc_wait);
                rd_d[i] = rd_q[i-1];
                av_d[i] = av_q[i-1];
            end
            if (!mc_wait) begin
                v_d[0]  = issue && id_rd_en && (id_rd != '0);
                rd_d[0] = id_rd;
                av_d[0] = (id_class == CLS_LOAD) ? SEL_W'(1) :
                          (id_class == CLS_SYS)  ? SEL_W'(DEPTH - 1) : '0;
                mc0_d   = (id_class == CLS_MC);
                fw_a_d  = issue && src_byp[0];
                fw_b_d  = issue && src_byp[1];
                sel_a_d = issue ? src_sel[0] : '0;
                sel_b_d = issue ? src_sel[1] : '0;
            end
            if (stall_fe && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q     <= '0;
            mc0_q   <= 1'b0;
            fw_a_q  <= 1'b0;
            fw_b_q  <= 1'b0;
            sel_a_q <= '0;
            sel_b_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= '0;
                av_q[i] <= '0;
            end
        end else begin
            v_q     <= v_d;
            mc0_q   <= mc0_d;
            fw_a_q  <= fw_a_d;
            fw_b_q  <= fw_b_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= rd_d[i];
                av_q[i] <= av_d[i];
            end
        end
    end

    assign fw_a      = fw_a_q;
    assign fw_b      = fw_b_q;
    assign fw_sel_a  = sel_a_q;
    assign fw_sel_b  = sel_b_q;
    assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_sb.sv
// tb/tb_hazard_sb.sv - directed vector bench for hazard_sb (DEPTH=3 forwarding, DEPTH=5 no-forwarding)
module tb_hazard_sb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ext_stall, flush, id_valid, id_rs1_en, id_rs2_en, id_rd_en, id_early, mc_done;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [1:0] id_class;

    logic        stall_fe, issue, fw_a, fw_b;
    logic [2:0]  stall_be;
    logic [1:0]  fw_sel_a, fw_sel_b;
    logic [31:0] stall_cnt;

    logic       stall_fe5, issue5, fw_a5, fw_b5;
    logic [4:0] stall_be5;
    logic [2:0] fw_sel_a5, fw_sel_b5, stall_cnt5;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_sb #(.DEPTH(3), .REG_W(5), .FWD_EN(1), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .ext_stall(ext_stall), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs1_en(id_rs1_en), .id_rs2(id_rs2), .id_rs2_en(id_rs2_en),
        .id_rd(id_rd), .id_rd_en(id_rd_en), .id_class(id_class), .id_early(id_early),
        .mc_done(mc_done), .stall_fe(stall_fe), .stall_be(stall_be), .issue(issue),
        .fw_a(fw_a), .fw_sel_a(fw_sel_a), .fw_b(fw_b), .fw_sel_b(fw_sel_b), .stall_cnt(stall_cnt)
    );

    hazard_sb #(.DEPTH(5), .REG_W(5), .FWD_EN(0), .CNT_W(3)) u_dut5 (
        .clk(clk), .rst(rst), .ext_stall(ext_stall), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs1_en(id_rs1_en), .id_rs2(id_rs2), .id_rs2_en(id_rs2_en),
        .id_rd(id_rd), .id_rd_en(id_rd_en), .id_class(id_class), .id_early(id_early),
        .mc_done(mc_done), .stall_fe(stall_fe5), .stall_be(stall_be5), .issue(issue5),
        .fw_a(fw_a5), .fw_sel_a(fw_sel_a5), .fw_b(fw_b5), .fw_sel_b(fw_sel_b5), .stall_cnt(stall_cnt5)
    );

    // ctl = {rst, ext_stall, flush, id_valid}; en = {rs1_en, rs2_en, rd_en}
    // e = {stall_fe, stall_be[2:0], issue, fw_a, fw_sel_a[1:0], fw_b, fw_sel_b[1:0]}
    typedef struct {
        logic [3:0]  ctl;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  en;
        logic [1:0]  cls;
        logic        early, mcd;
        logic [10:0] e;
        int          cnt;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic [3:0] ctl, input int rs1, input int rs2, input int rd,
                       input logic [2:0] en, input int cls, input logic early, input logic mcd,
                       input logic [10:0] e, input int cnt);
        vec_t t;
        t.ctl = ctl; t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rd = 5'(rd);
        t.en = en; t.cls = 2'(cls); t.early = early; t.mcd = mcd; t.e = e; t.cnt = cnt;
        tv.push_back(t);
    endtask

    task automatic apply(input vec_t t);
        {rst, ext_stall, flush, id_valid} = t.ctl;
        {id_rs1_en, id_rs2_en, id_rd_en}  = t.en;
        id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd;
        id_class = t.cls; id_early = t.early; mc_done = t.mcd;
    endtask

    task automatic drive_id(input logic r, input int rs1, input int rs2, input int rd,
                            input logic [2:0] en, input logic v);
        rst = r; ext_stall = 1'b0; flush = 1'b0; id_valid = v;
        {id_rs1_en, id_rs2_en, id_rd_en} = en;
        id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
        id_class = 2'd0; id_early = 1'b0; mc_done = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic measure(output int stalls);
        stalls = 0;
        for (int c = 0; c < 12; c++) begin
            if (issue5) break;
            stalls++;
            @(negedge clk); #2;
        end
    endtask

    initial begin
        int st;
        drive_id(1'b1, 0, 0, 0, 3'b000, 1'b0);

        add(4'b1000,  0, 0, 0, 3'b000, 0, 0, 0, 11'b1_111_0_000_000, 0);   // reset state
        add(4'b0001,  1, 2, 5, 3'b111, 0, 0, 0, 11'b0_000_1_000_000, 0);   // ALU x5
        add(4'b0001,  5, 3, 9, 3'b111, 0, 0, 0, 11'b0_000_1_000_000, 0);   // reads x5
        add(4'b0001, 10, 5, 6, 3'b111, 1, 0, 0, 11'b0_000_1_100_000, 0);   // load x6
        add(4'b0001,  6, 0,11, 3'b111, 0, 0, 0, 11'b1_000_0_000_101, 0);   // load-use stall
        add(4'b0001,  6, 0,11, 3'b111, 0, 0, 0, 11'b0_000_1_000_000, 1);
        add(4'b0001, 11, 0, 7, 3'b011, 0, 0, 0, 11'b0_000_1_101_000, 1);   // ALU x7, rs1 disabled
        add(4'b0001,  7, 0, 0, 3'b110, 0, 1, 0, 11'b1_000_0_000_000, 1);   // branch reads x7
        add(4'b0001,  7, 0, 0, 3'b110, 0, 1, 0, 11'b1_000_0_000_000, 2);
        add(4'b0001,  7, 0, 0, 3'b110, 0, 1, 0, 11'b0_000_1_000_000, 3);
        add(4'b0000,  0, 0, 0, 3'b000, 0, 0, 0, 11'b0_000_0_110_000, 3);
        add(4'b0001,  1, 2, 8, 3'b111, 3, 0, 0, 11'b0_000_1_000_000, 3);   // div x8
        for (int k = 0; k < 5; k++)
            add(4'b0001, 8, 0, 12, 3'b111, 0, 0, 0, 11'b1_001_0_000_000, 3 + k);
        add(4'b0001,  8, 0,12, 3'b111, 0, 0, 1, 11'b0_000_1_000_000, 8);   // mc_done
        add(4'b0001, 12, 0, 6, 3'b111, 1, 0, 0, 11'b0_000_1_100_000, 8);   // load x6
        add(4'b0101,  6, 8,13, 3'b111, 0, 0, 0, 11'b1_111_0_100_000, 8);   // ext_stall + hazard
        add(4'b0101,  6, 8,13, 3'b111, 0, 0, 0, 11'b1_111_0_100_000, 8);
        add(4'b0001,  6, 8,13, 3'b111, 0, 0, 0, 11'b1_000_0_100_000, 8);
        add(4'b0001,  6, 8,13, 3'b111, 0, 0, 0, 11'b0_000_1_000_000, 9);
        add(4'b0011, 13, 0, 0, 3'b110, 0, 1, 0, 11'b0_000_0_101_000, 9);   // flushed hazard
        add(4'b0001,  0, 0,14, 3'b001, 2, 0, 0, 11'b0_000_1_000_000, 9);   // CSR x14
        add(4'b0001, 14,13,15, 3'b111, 0, 0, 0, 11'b1_000_0_000_000, 9);
        add(4'b0001, 14,13,15, 3'b111, 0, 0, 0, 11'b1_000_0_000_000, 10);
        add(4'b0001, 14,13,15, 3'b111, 0, 0, 0, 11'b0_000_1_000_000, 11);
        add(4'b0000,  0, 0, 0, 3'b000, 0, 0, 0, 11'b0_000_0_110_000, 11);
        add(4'b0001,  0, 0, 8, 3'b001, 3, 0, 0, 11'b0_000_1_000_000, 11);  // div, then rst
        add(4'b0001,  0, 0, 1, 3'b001, 0, 0, 0, 11'b1_001_0_000_000, 11);
        add(4'b1001,  0, 0, 1, 3'b001, 0, 0, 0, 11'b1_111_0_000_000, 12);
        add(4'b0001,  0, 0, 1, 3'b001, 0, 0, 0, 11'b0_000_1_000_000, 0);
        add(4'b0001,  0, 0, 0, 3'b001, 0, 0, 0, 11'b0_000_1_000_000, 0);   // x0 writes
        add(4'b0001,  0, 0, 0, 3'b111, 0, 0, 0, 11'b0_000_1_000_000, 0);
        add(4'b1001,  0, 0, 0, 3'b111, 0, 0, 0, 11'b1_111_0_000_000, 0);
        add(4'b0001,  0, 0, 0, 3'b111, 0, 1, 0, 11'b0_000_1_000_000, 0);

        repeat (2) @(posedge clk);
        for (int k = 0; k < tv.size(); k++) begin
            @(negedge clk);
            apply(tv[k]);
            #2;
            chk($sformatf("vec%0d_outs", k),
                {21'b0, stall_fe, stall_be, issue, fw_a, fw_sel_a, fw_b, fw_sel_b}, {21'b0, tv[k].e});
            chk($sformatf("vec%0d_cnt", k), stall_cnt, tv[k].cnt);
        end

        // FWD_EN=0, DEPTH=5, 3-bit saturating counter
        @(negedge clk); drive_id(1'b1, 0, 0, 0, 3'b000, 1'b0); #2;
        chk("d5_rst_be", {27'b0, stall_be5}, 32'h1f);
        @(negedge clk); drive_id(1'b0, 0, 0, 5, 3'b001, 1'b1); #2;
        chk("d5_first_issue", {30'b0, issue5, stall_fe5}, 32'h2);
        @(negedge clk); drive_id(1'b0, 5, 0, 9, 3'b111, 1'b1); #2;
        measure(st);
        chk("d5_stalls_x5", st, 5);
        @(negedge clk); drive_id(1'b0, 9, 0, 10, 3'b111, 1'b1); #2;
        chk("d5_no_bypass", {31'b0, fw_a5}, 0);
        chk("d5_cnt5", {29'b0, stall_cnt5}, 5);
        measure(st);
        chk("d5_stalls_x9", st, 5);
        @(negedge clk); drive_id(1'b0, 0, 0, 0, 3'b001, 1'b1); #2;
        chk("d5_cnt_sat", {29'b0, stall_cnt5}, 7);
        @(negedge clk); drive_id(1'b0, 0, 0, 3, 3'b111, 1'b1); #2;
        chk("d5_x0_no_stall", {30'b0, issue5, stall_fe5}, 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
